// File: rtl/ofm_sram_arbiter_if.sv
// Requester, clear-control and SRAM-wrapper signals of the OFM SRAM arbiter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface ofm_sram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 11
);
  logic                  wr_req;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  logic                  rd_req;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  rd_gnt;
  logic                  rd_rvalid;
  logic [DATA_WIDTH-1:0] rd_rdata;
  logic                  clr_start;
  logic                  clr_busy;
  logic                  frame_done;
  logic [ADDR_BITS:0]    wr_count;
  logic                  sram_write_en;
  logic [ADDR_BITS-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, sram_rdata,
    output wr_gnt, rd_gnt, rd_rvalid, rd_rdata, clr_busy, frame_done, wr_count,
           sram_write_en, sram_addr, sram_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start, sram_rdata,
    input  wr_gnt, rd_gnt, rd_rvalid, rd_rdata, clr_busy, frame_done, wr_count,
           sram_write_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/ofm_sram_arbiter.sv
// Shares one single-port OFM SRAM between the conv write stream and a reader,
// with round-robin arbitration, a hardware zero-fill clear and a frame write counter.
module ofm_sram_arbiter #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_BITS   = 11,
  parameter int unsigned FRAME_WORDS = 784
) (
  input logic              clk,
  input logic              rst,
  ofm_sram_arbiter_if.slave bus
);

  localparam int unsigned           CNT_W     = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0]      FRAME_CNT = CNT_W'(FRAME_WORDS);
  localparam logic [ADDR_BITS-1:0]  CLR_LAST  = ADDR_BITS'(FRAME_WORDS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {RR_WRITE, RR_READ} rr_t;

  state_t                state;
  state_t                state_nxt;
  rr_t                   rr_last;
  logic                  wr_gnt;
  logic                  rd_gnt;
  logic                  sram_we;
  logic [ADDR_BITS-1:0]  sram_addr;
  logic [ADDR_BITS-1:0]  addr_shadow;
  logic [ADDR_BITS-1:0]  clr_cnt;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic                  clr_last;
  logic                  rd_rvalid;
  logic                  clr_busy;
  logic                  frame_done;
  logic [CNT_W-1:0]      wr_count;

  // Arbitration and SRAM drive; clr_start beats any request, ties go to the one not served last.
  always_comb begin
    state_nxt  = state;
    wr_gnt     = 1'b0;
    rd_gnt     = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = addr_shadow;
    sram_wdata = '0;
    clr_last   = (clr_cnt == CLR_LAST);
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state_nxt = CLEAR;
          end else if (bus.wr_req && (!bus.rd_req || rr_last == RR_READ)) begin
            wr_gnt = 1'b1;
          end else if (bus.rd_req) begin
            rd_gnt = 1'b1;
          end
        end
        CLEAR: begin
          sram_we   = 1'b1;
          sram_addr = clr_cnt;
          if (clr_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (wr_gnt) begin
      sram_we    = 1'b1;
      sram_addr  = bus.wr_addr;
      sram_wdata = bus.wr_data;
    end
    if (rd_gnt) sram_addr = bus.rd_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= RR_READ;
      rd_rvalid   <= 1'b0;
      clr_busy    <= 1'b0;
      frame_done  <= 1'b0;
      wr_count    <= '0;
      clr_cnt     <= '0;
      addr_shadow <= '0;
    end else begin
      state       <= state_nxt;
      rd_rvalid   <= rd_gnt;
      clr_busy    <= (state_nxt == CLEAR);
      addr_shadow <= sram_addr;
      frame_done  <= 1'b0;
      if (wr_gnt) begin
        rr_last <= RR_WRITE;
      end else if (rd_gnt) begin
        rr_last <= RR_READ;
      end
      if (state == CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      // Count saturates at a full frame, so frame_done can only fire once per clear.
      if (state == CLEAR && clr_last) begin
        wr_count <= '0;
      end else if (wr_gnt && wr_count < FRAME_CNT) begin
        wr_count   <= wr_count + 1'b1;
        frame_done <= (wr_count == FRAME_CNT - 1'b1);
      end
    end
  end

  assign bus.wr_gnt        = wr_gnt;
  assign bus.rd_gnt        = rd_gnt;
  assign bus.rd_rvalid     = rd_rvalid;
  assign bus.rd_rdata      = bus.sram_rdata;
  assign bus.clr_busy      = clr_busy;
  assign bus.frame_done    = frame_done;
  assign bus.wr_count      = wr_count;
  assign bus.sram_write_en = sram_we;
  assign bus.sram_addr     = sram_addr;
  assign bus.sram_wdata    = sram_wdata;

endmodule

// File: tb/tb_ofm_sram_arbiter.sv
// Directed bench for ofm_sram_arbiter with a behavioural 2048x8 SRAM (1-cycle read).
module tb_ofm_sram_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ofm_sram_arbiter_if #(.DATA_WIDTH(8), .ADDR_BITS(11)) bus ();

  ofm_sram_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(11), .FRAME_WORDS(784)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:2047];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_write_en) mem[bus.sram_addr] <= bus.sram_wdata;
    bus.sram_rdata <= mem[bus.sram_addr];
  end

  typedef struct {
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [10:0] rd_addr;
    logic        wg;
    logic        rg;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic        rv;
    logic [7:0]  rdata;
    logic [11:0] cnt;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    bus.clr_start = 1'b0;
    #1;
    chk("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    chk("rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    chk("rst_write_en", 32'(bus.sram_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    #1;
    chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
    chk("rst_wr_count", 32'(bus.wr_count), 32'd0);
    chk("rst_rvalid", 32'(bus.rd_rvalid), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [10:0] a, input logic [7:0] d);
    bus.wr_req = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    #1;
    chk("write_gnt", 32'(bus.wr_gnt), 32'd1);
    @(negedge clk);
    bus.wr_req = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [10:0] a, input logic [7:0] exp);
    bus.rd_req = 1'b1;
    bus.rd_addr = a;
    #1;
    chk({name, "_gnt"}, 32'(bus.rd_gnt), 32'd1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    chk({name, "_rvalid"}, 32'(bus.rd_rvalid), 32'd1);
    chk({name, "_rdata"}, 32'(bus.rd_rdata), 32'(exp));
    @(negedge clk);
  endtask

  // Counts clr_busy cycles and any cycle whose SRAM drive or grants differ from the zero-fill pattern.
  task automatic run_clear(output int busy, output int bad, input int restart_at);
    busy = 0;
    bad  = 0;
    for (int g = 0; g < 2000; g++) begin
      #1;
      if (!bus.clr_busy) break;
      if (bus.wr_gnt || bus.rd_gnt || !bus.sram_write_en ||
          bus.sram_addr != 11'(busy) || bus.sram_wdata != 8'h00) bad++;
      busy++;
      @(negedge clk);
      bus.clr_start = (busy == restart_at);
    end
    bus.clr_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int bad;
    int pulses;
    int gbad;

    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    bus.clr_start = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

    vec[0]  = '{1'b1, 11'd5, 8'hA7, 1'b0, 11'd0,    1'b1, 1'b0, 1'b1, 11'd5,    8'hA7, 1'b0, 8'h00, 12'd0};
    vec[1]  = '{1'b0, 11'd0, 8'h00, 1'b1, 11'd5,    1'b0, 1'b1, 1'b0, 11'd5,    8'h00, 1'b0, 8'h00, 12'd1};
    vec[2]  = '{1'b0, 11'd0, 8'h00, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 11'd5,    8'h00, 1'b1, 8'hA7, 12'd1};
    vec[3]  = '{1'b1, 11'd7, 8'h3C, 1'b1, 11'd5,    1'b1, 1'b0, 1'b1, 11'd7,    8'h3C, 1'b0, 8'h00, 12'd1};
    vec[4]  = '{1'b1, 11'd8, 8'h11, 1'b1, 11'd5,    1'b0, 1'b1, 1'b0, 11'd5,    8'h00, 1'b0, 8'h00, 12'd2};
    vec[5]  = '{1'b1, 11'd8, 8'h11, 1'b1, 11'd8,    1'b1, 1'b0, 1'b1, 11'd8,    8'h11, 1'b1, 8'hA7, 12'd2};
    vec[6]  = '{1'b0, 11'd0, 8'h00, 1'b1, 11'd8,    1'b0, 1'b1, 1'b0, 11'd8,    8'h00, 1'b0, 8'h00, 12'd3};
    vec[7]  = '{1'b0, 11'd0, 8'h00, 1'b1, 11'd7,    1'b0, 1'b1, 1'b0, 11'd7,    8'h00, 1'b1, 8'h11, 12'd3};
    vec[8]  = '{1'b0, 11'd0, 8'h00, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 11'd7,    8'h00, 1'b1, 8'h3C, 12'd3};
    vec[9]  = '{1'b0, 11'd0, 8'h00, 1'b1, 11'd2047, 1'b0, 1'b1, 1'b0, 11'd2047, 8'h00, 1'b0, 8'h00, 12'd3};
    vec[10] = '{1'b0, 11'd0, 8'h00, 1'b0, 11'd0,    1'b0, 1'b0, 1'b0, 11'd2047, 8'h00, 1'b1, 8'h00, 12'd3};

    // Vector table: single requests, ties, read latency, address passthrough.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.wr_req  = vec[i].wr_req;
      bus.wr_addr = vec[i].wr_addr;
      bus.wr_data = vec[i].wr_data;
      bus.rd_req  = vec[i].rd_req;
      bus.rd_addr = vec[i].rd_addr;
      #1;
      chk($sformatf("v%0d_wr_gnt", i), 32'(bus.wr_gnt), 32'(vec[i].wg));
      chk($sformatf("v%0d_rd_gnt", i), 32'(bus.rd_gnt), 32'(vec[i].rg));
      chk($sformatf("v%0d_write_en", i), 32'(bus.sram_write_en), 32'(vec[i].we));
      chk($sformatf("v%0d_sram_addr", i), 32'(bus.sram_addr), 32'(vec[i].addr));
      chk($sformatf("v%0d_sram_wdata", i), 32'(bus.sram_wdata), 32'(vec[i].wdata));
      chk($sformatf("v%0d_rvalid", i), 32'(bus.rd_rvalid), 32'(vec[i].rv));
      if (vec[i].rv) chk($sformatf("v%0d_rdata", i), 32'(bus.rd_rdata), 32'(vec[i].rdata));
      chk($sformatf("v%0d_wr_count", i), 32'(bus.wr_count), 32'(vec[i].cnt));
      @(negedge clk);
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;

    // Both requesters held from reset: W,R,W,R,W,R.
    do_reset();
    bus.wr_req = 1'b1;
    bus.wr_addr = 11'd20;
    bus.wr_data = 8'h20;
    bus.rd_req = 1'b1;
    bus.rd_addr = 11'd20;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt%0d_wr_gnt", i), 32'(bus.wr_gnt), 32'(i % 2 == 0));
      chk($sformatf("alt%0d_rd_gnt", i), 32'(bus.rd_gnt), 32'(i % 2 == 1));
      chk($sformatf("alt%0d_rvalid", i), 32'(bus.rd_rvalid), 32'(i > 0 && i % 2 == 0));
      @(negedge clk);
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    #1;
    chk("alt6_rvalid", 32'(bus.rd_rvalid), 32'd1);
    chk("alt6_rdata", 32'(bus.rd_rdata), 32'h20);
    @(negedge clk);

    // Full frame stream, then one write past the frame.
    do_reset();
    pulses = 0;
    gbad = 0;
    for (int a = 0; a < 784; a++) begin
      bus.wr_req = 1'b1;
      bus.wr_addr = 11'(a);
      bus.wr_data = 8'(a);
      #1;
      if (!bus.wr_gnt || !bus.sram_write_en) gbad++;
      if (bus.frame_done) pulses++;
      @(negedge clk);
    end
    chk("stream_grants", 32'(gbad), 32'd0);
    chk("stream_early_done", 32'(pulses), 32'd0);
    bus.wr_addr = 11'd784;
    bus.wr_data = 8'h10;
    #1;
    chk("frame_done_pulse", 32'(bus.frame_done), 32'd1);
    chk("frame_count", 32'(bus.wr_count), 32'd784);
    chk("extra_wr_gnt", 32'(bus.wr_gnt), 32'd1);
    chk("extra_addr", 32'(bus.sram_addr), 32'd784);
    @(negedge clk);
    bus.wr_req = 1'b0;
    #1;
    chk("frame_done_single", 32'(bus.frame_done), 32'd0);
    chk("count_saturated", 32'(bus.wr_count), 32'd784);
    @(negedge clk);
    do_read("rd783", 11'd783, 8'h0F);
    do_read("rd784", 11'd784, 8'h10);
    do_read("rd255", 11'd255, 8'hFF);

    // Clear with writer also requesting; a mid-clear clr_start must not restart it.
    bus.wr_req = 1'b1;
    bus.wr_addr = 11'd300;
    bus.wr_data = 8'h77;
    bus.clr_start = 1'b1;
    #1;
    chk("clr_start_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    chk("clr_start_write_en", 32'(bus.sram_write_en), 32'd0);
    @(negedge clk);
    bus.clr_start = 1'b0;
    run_clear(busy, bad, 400);
    chk("clear_cycles", 32'(busy), 32'd784);
    chk("clear_pattern", 32'(bad), 32'd0);
    chk("clear_wr_count", 32'(bus.wr_count), 32'd0);
    chk("post_clear_wr_gnt", 32'(bus.wr_gnt), 32'd1);
    @(negedge clk);
    bus.wr_req = 1'b0;
    do_read("clr_rd100", 11'd100, 8'h00);
    do_read("clr_rd783", 11'd783, 8'h00);
    do_read("clr_rd784", 11'd784, 8'h10);
    do_read("clr_rd300", 11'd300, 8'h77);

    // Reset at clear cycle 300 aborts to IDLE.
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (!bus.clr_busy) bad++;
      @(negedge clk);
    end
    #1;
    chk("abort_prefix_busy", 32'(bad), 32'd0);
    chk("abort_cycle_addr", 32'(bus.sram_addr), 32'd300);
    chk("abort_count_kept", 32'(bus.wr_count), 32'd1);
    rst = 1'b1;
    bus.wr_req = 1'b1;
    bus.wr_addr = 11'd64;
    bus.wr_data = 8'h99;
    #1;
    chk("abort_rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    chk("abort_rst_write_en", 32'(bus.sram_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_clr_busy", 32'(bus.clr_busy), 32'd0);
    chk("abort_wr_count", 32'(bus.wr_count), 32'd0);
    chk("abort_idle_wr_gnt", 32'(bus.wr_gnt), 32'd1);
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    run_clear(busy, bad, 0);
    chk("reclear_cycles", 32'(busy), 32'd784);
    chk("reclear_pattern", 32'(bad), 32'd0);
    @(negedge clk);

    // Read granted just before clr_start still returns the old data.
    do_write(11'd10, 8'h5A);
    bus.rd_req = 1'b1;
    bus.rd_addr = 11'd10;
    #1;
    chk("pre_clear_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.clr_start = 1'b1;
    #1;
    chk("pre_clear_rvalid", 32'(bus.rd_rvalid), 32'd1);
    chk("pre_clear_rdata", 32'(bus.rd_rdata), 32'h5A);
    @(negedge clk);
    bus.clr_start = 1'b0;
    run_clear(busy, bad, 0);
    chk("late_clear_cycles", 32'(busy), 32'd784);
    @(negedge clk);
    do_read("late_rd10", 11'd10, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
